// File: rtl/mem_access.sv
// Memory-access stage: splits LOAD/STORE into byte requests (little-endian),
// assembles load data with sign/zero extension, stalls the pipeline meanwhile.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_mem_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic [1:0]  state_dbg
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [31:0] asm_buf;
  logic [31:0] load_ext;
  logic [1:0]  last_cnt;
  logic        is_load, is_store, is_mem;
  logic        byte_done;

  assign is_load   = (opcode_i == OP_LOAD);
  assign is_store  = (opcode_i == OP_STORE);
  assign is_mem    = is_load | is_store;
  assign state_dbg = state;

  // Handshake: a byte request (mem_req_o) holds address/data stable until the
  // cycle it is accepted; a byte completes on a rising edge where
  // mem_req_o && mem_ack_i, and read data is valid in that same cycle.
  assign byte_done = (state == ACCESS) && rdy && mem_ack_i;

  // Index of the final byte: 1, 2 or 4 bytes; width code 11 behaves as a word.
  always_comb begin
    case (func3_i[1:0])
      2'b00:   last_cnt = 2'd0;
      2'b01:   last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      asm_buf <= 32'd0;
    end else if (rdy) begin
      if (state == IDLE && is_mem) begin
        cnt     <= 2'd0;
        asm_buf <= 32'd0;
      end else if (byte_done) begin
        if (is_load) asm_buf[{cnt, 3'b000} +: 8] <= mem_rdata_i;
        cnt <= cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_mem) state_nxt = ACCESS;
      ACCESS:  if (byte_done && cnt == last_cnt) state_nxt = DONE;
      DONE:    if (!stall_mem_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (func3_i)
      3'b000:  load_ext = {{24{asm_buf[7]}}, asm_buf[7:0]};
      3'b001:  load_ext = {{16{asm_buf[15]}}, asm_buf[15:0]};
      3'b100:  load_ext = {24'd0, asm_buf[7:0]};
      3'b101:  load_ext = {16'd0, asm_buf[15:0]};
      default: load_ext = asm_buf;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 8'd0;
    stallreq_o  = 1'b0;
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stallreq_o = 1'b1;
        end else begin
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end
      ACCESS: begin
        // A global stall withdraws the request but keeps the stage stalled.
        mem_req_o   = rdy;
        mem_we_o    = is_store;
        mem_addr_o  = mem_addr_i + {30'd0, cnt};
        mem_wdata_o = wdata_i[{cnt, 3'b000} +: 8];
        stallreq_o  = 1'b1;
      end
      DONE: begin
        if (is_load) begin
          wreg_o  = wreg_i;
          wdata_o = load_ext;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a byte-wide memory responder with
// configurable ack latency plus one task per scenario with inline checks.
module tb_mem_access;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic [31:0] mem_addr_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        stall_mem_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .opcode_i(opcode_i), .func3_i(func3_i), .mem_addr_i(mem_addr_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .stall_mem_i(stall_mem_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [7:0]  mem_bytes [logic [31:0]];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] done_addr_q[$];
  logic [7:0]  done_data_q[$];
  logic        done_we_q[$];

  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = 8'd0;
  end

  always @(negedge clk) begin
    if (rst || !mem_req_o) begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 8'd0;
      if (rst) wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = mem_bytes.exists(mem_addr_o) ? mem_bytes[mem_addr_o] : 8'h00;
      wait_cnt    = 0;
    end else begin
      mem_ack_i = 1'b0;
      wait_cnt++;
    end
  end

  // Log every byte transfer that actually completes at a clock edge.
  always @(posedge clk) begin
    if (!rst && mem_req_o && mem_ack_i) begin
      done_addr_q.push_back(mem_addr_o);
      done_we_q.push_back(mem_we_o);
      done_data_q.push_back(mem_we_o ? mem_wdata_o : mem_rdata_i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    done_addr_q.delete();
    done_data_q.delete();
    done_we_q.delete();
  endtask

  task automatic drive_idle();
    opcode_i = 7'd0; func3_i = 3'd0; mem_addr_i = 32'd0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; stall_mem_i = 1'b0;
  endtask

  task automatic run_access(input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] wd, output int stalls,
                            output int reqs, output bit timed_out);
    @(posedge clk); #1;
    opcode_i = op; func3_i = f3; mem_addr_i = addr;
    wdata_i = data; wd_i = wd; wreg_i = 1'b1;
    clear_log();
    stalls = 0; reqs = 0; timed_out = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (mem_req_o) reqs++;
      if (state_dbg == S_DONE) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic end_access();
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; drive_idle();
    repeat (2) @(posedge clk);
    #1 rdy = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    n_cmp++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
    n_cmp++; if (mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    n_cmp++; if (mem_wdata_o !== 8'd0) begin n_fail++; $display("FAIL reset_mwdata: got %h want 0", mem_wdata_o); end
    n_cmp++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
    n_cmp++; if (wd_o !== 5'd0) begin n_fail++; $display("FAIL reset_wd: got %0d want 0", wd_o); end
    n_cmp++; if (wreg_o !== 1'b0) begin n_fail++; $display("FAIL reset_wreg: got %b want 0", wreg_o); end
    n_cmp++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
  endtask

  task automatic test_pass_through();
    @(posedge clk); #1;
    opcode_i = OP_ALU; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
    #2;
    n_cmp++; if (wd_o !== 5'd5) begin n_fail++; $display("FAIL pt_wd: got %0d want 5", wd_o); end
    n_cmp++; if (wreg_o !== 1'b1) begin n_fail++; $display("FAIL pt_wreg: got %b want 1", wreg_o); end
    n_cmp++; if (wdata_o !== 32'h1234) begin n_fail++; $display("FAIL pt_wdata: got %h want 00001234", wdata_o); end
    n_cmp++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL pt_stall: got %b want 0", stallreq_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL pt_req: got %b want 0", mem_req_o); end
    @(negedge clk);
    n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL pt_state: got %0d want %0d", state_dbg, S_IDLE); end
    @(posedge clk); #1 drive_idle();
  endtask

  task automatic test_load_word();
    int stalls, reqs;
    bit to;
    run_access(OP_LOAD, 3'b010, 32'h100, 32'd0, 5'd7, stalls, reqs, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL lw_timeout: DONE not reached within budget"); end
    n_cmp++; if (reqs != 4) begin n_fail++; $display("FAIL lw_req_cycles: got %0d want 4", reqs); end
    n_cmp++; if (stalls != 5) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 5", stalls); end
    n_cmp++; if (done_addr_q.size() != 4) begin n_fail++; $display("FAIL lw_bytes: got %0d want 4", done_addr_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (done_addr_q[i] !== 32'h100 + i) begin n_fail++; $display("FAIL lw_addr%0d: got %h want %h", i, done_addr_q[i], 32'h100 + i); end
    end
    n_cmp++; if (wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL lw_wdata: got %h want 12345678", wdata_o); end
    n_cmp++; if (wreg_o !== 1'b1) begin n_fail++; $display("FAIL lw_wreg: got %b want 1", wreg_o); end
    n_cmp++; if (wd_o !== 5'd7) begin n_fail++; $display("FAIL lw_wd: got %0d want 7", wd_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL lw_done_req: got %b want 0", mem_req_o); end
    end_access();
  endtask

  task automatic test_extension();
    logic [2:0]  f3s  [4];
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    int stalls, reqs;
    bit to;
    f3s[0] = 3'b000; adrs[0] = 32'h20; exps[0] = 32'hFFFFFF80;
    f3s[1] = 3'b100; adrs[1] = 32'h20; exps[1] = 32'h00000080;
    f3s[2] = 3'b001; adrs[2] = 32'h30; exps[2] = 32'hFFFF8000;
    f3s[3] = 3'b101; adrs[3] = 32'h30; exps[3] = 32'h00008000;
    for (int k = 0; k < 4; k++) begin
      run_access(OP_LOAD, f3s[k], adrs[k], 32'd0, 5'd3, stalls, reqs, to);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ext%0d_timeout: DONE not reached", k); end
      n_cmp++; if (wdata_o !== exps[k]) begin n_fail++; $display("FAIL ext%0d_wdata: got %h want %h", k, wdata_o, exps[k]); end
      n_cmp++; if (reqs != ((f3s[k][1:0] == 2'b00) ? 1 : 2)) begin n_fail++; $display("FAIL ext%0d_reqs: got %0d", k, reqs); end
      end_access();
    end
  endtask

  task automatic test_store_wrap();
    int stalls, reqs, extra;
    bit to;
    ack_delay = 2;
    run_access(OP_STORE, 3'b001, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd9, stalls, reqs, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL sh_timeout: DONE not reached"); end
    n_cmp++; if (reqs != 6) begin n_fail++; $display("FAIL sh_req_cycles: got %0d want 6", reqs); end
    n_cmp++; if (done_addr_q.size() != 2) begin n_fail++; $display("FAIL sh_bytes: got %0d want 2", done_addr_q.size()); end
    else begin
      n_cmp++; if (done_addr_q[0] !== 32'hFFFFFFFF || done_data_q[0] !== 8'hDD || done_we_q[0] !== 1'b1) begin
        n_fail++; $display("FAIL sh_byte0: got %h/%h/%b want ffffffff/dd/1", done_addr_q[0], done_data_q[0], done_we_q[0]); end
      n_cmp++; if (done_addr_q[1] !== 32'h0 || done_data_q[1] !== 8'hCC || done_we_q[1] !== 1'b1) begin
        n_fail++; $display("FAIL sh_byte1: got %h/%h/%b want 00000000/cc/1", done_addr_q[1], done_data_q[1], done_we_q[1]); end
    end
    n_cmp++; if (wreg_o !== 1'b0) begin n_fail++; $display("FAIL sh_wreg: got %b want 0", wreg_o); end
    n_cmp++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL sh_wdata: got %h want 0", wdata_o); end
    end_access();
    ack_delay = 0;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_req_o) extra++;
    end
    n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL sh_extra_reqs: got %0d want 0", extra); end
  endtask

  task automatic test_stall_and_rdy();
    int reqs, hold_reqs;
    bit to;
    @(posedge clk); #1;
    opcode_i = OP_LOAD; func3_i = 3'b010; mem_addr_i = 32'h100;
    wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'd0; stall_mem_i = 1'b1;
    clear_log();
    reqs = 0;
    @(negedge clk);
    @(negedge clk);
    if (mem_req_o) reqs++;
    @(posedge clk); #1 rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rdy%0d_req: got %b want 0", k, mem_req_o); end
      n_cmp++; if (state_dbg !== S_ACCESS) begin n_fail++; $display("FAIL rdy%0d_state: got %0d want %0d", k, state_dbg, S_ACCESS); end
      n_cmp++; if (mem_addr_o !== 32'h101) begin n_fail++; $display("FAIL rdy%0d_addr: got %h want 00000101", k, mem_addr_o); end
      n_cmp++; if (stallreq_o !== 1'b1) begin n_fail++; $display("FAIL rdy%0d_stall: got %b want 1", k, stallreq_o); end
      @(posedge clk);
    end
    #1 rdy = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_o) reqs++;
      if (state_dbg == S_DONE) begin to = 1'b0; break; end
    end
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL hold_timeout: DONE not reached"); end
    hold_reqs = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_req_o) hold_reqs++;
      n_cmp++; if (state_dbg !== S_DONE) begin n_fail++; $display("FAIL hold%0d_state: got %0d want %0d", k, state_dbg, S_DONE); end
      n_cmp++; if (wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL hold%0d_wdata: got %h want 12345678", k, wdata_o); end
    end
    n_cmp++; if (reqs + hold_reqs != 4) begin n_fail++; $display("FAIL hold_reqs: got %0d want 4", reqs + hold_reqs); end
    n_cmp++; if (done_addr_q.size() != 4) begin n_fail++; $display("FAIL hold_bytes: got %0d want 4", done_addr_q.size()); end
    end_access();
    @(negedge clk);
    n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL hold_release: got %0d want %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_reset_mid_store();
    int stalls, reqs;
    bit to;
    @(posedge clk); #1;
    opcode_i = OP_STORE; func3_i = 3'b010; mem_addr_i = 32'h200;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h44332211; stall_mem_i = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; drive_idle();
    @(negedge clk);
    n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d want %0d", state_dbg, S_IDLE); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b want 0", mem_req_o); end
    n_cmp++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stallreq_o); end
    n_cmp++; if (done_addr_q.size() != 2) begin n_fail++; $display("FAIL rst_mid_bytes: got %0d want 2", done_addr_q.size()); end
    else begin
      n_cmp++; if (done_addr_q[0] !== 32'h200 || done_data_q[0] !== 8'h11) begin n_fail++; $display("FAIL rst_mid_b0: got %h/%h want 00000200/11", done_addr_q[0], done_data_q[0]); end
      n_cmp++; if (done_addr_q[1] !== 32'h201 || done_data_q[1] !== 8'h22) begin n_fail++; $display("FAIL rst_mid_b1: got %h/%h want 00000201/22", done_addr_q[1], done_data_q[1]); end
    end
    run_access(OP_LOAD, 3'b010, 32'h100, 32'd0, 5'd2, stalls, reqs, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL post_rst_timeout: DONE not reached"); end
    n_cmp++; if (wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL post_rst_wdata: got %h want 12345678", wdata_o); end
    n_cmp++; if (reqs != 4) begin n_fail++; $display("FAIL post_rst_reqs: got %0d want 4", reqs); end
    end_access();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    mem_bytes[32'h100] = 8'h78; mem_bytes[32'h101] = 8'h56;
    mem_bytes[32'h102] = 8'h34; mem_bytes[32'h103] = 8'h12;
    mem_bytes[32'h20]  = 8'h80;
    mem_bytes[32'h30]  = 8'h00; mem_bytes[32'h31]  = 8'h80;
    test_reset();
    test_pass_through();
    test_load_word();
    test_extension();
    test_store_wrap();
    test_stall_and_rdy();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
